// File: rtl/stump_mem_arbiter_pkg.sv
// Shared Stump memory-arbiter definitions: bus width, FSM state encodings
// and the default starvation limit used by the optional starvation guard
// (enabled with the STUMP_ARB_STARVE_GUARD_EN macro).
package stump_mem_arbiter_pkg;

  localparam int DATA_W               = 16;
  localparam int STARVE_CNT_W         = 3;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_ACK  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/stump_mem_arbiter_if.sv
// Bus bundle between the Stump CPU, the DMA engine, the single-port memory
// and the arbiter that shares the memory port between the two requesters.
//
// Handshake: the CPU presents cpu_req each cycle it needs the port; when
// cpu_stall=1 the access was not performed and the CPU holds and retries.
// The DMA raises dma_req and holds it (with stable wen/addr/wdata) until it
// sees dma_done; dma_gnt marks the cycle the access hit memory and dma_done
// follows exactly one cycle later carrying registered read data.
interface stump_mem_arbiter_if;
  import stump_mem_arbiter_pkg::*;

  logic              cpu_req;
  logic              cpu_wen;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_wen;
  logic [DATA_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_done;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_ren;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  dma_req, dma_wen, dma_addr, dma_wdata,
    output dma_gnt, dma_done, dma_rdata,
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester / memory side.
  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output dma_req, dma_wen, dma_addr, dma_wdata,
    input  dma_gnt, dma_done, dma_rdata,
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/stump_starve_counter.sv
// Saturating starvation counter: counts denied DMA cycles, clears on demand,
// never wraps, and flags when the count has reached LIMIT.
module stump_starve_counter
  import stump_mem_arbiter_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  logic [STARVE_CNT_W-1:0] count_q;
  logic [STARVE_CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise increment and hold at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q >= STARVE_CNT_W'(LIMIT));

endmodule

// File: rtl/stump_mem_arbiter.sv
// Stump memory-port arbiter. The CPU has priority; a DMA access takes the
// port for one cycle (IDLE -> ACK) and the ACK cycle always belongs to the
// CPU, so the CPU is served at least every second cycle.
// Build option STUMP_ARB_STARVE_GUARD_EN: a starvation counter forces a DMA
// grant after STARVE_LIMIT consecutive denied cycles; without it the DMA is
// granted only while the CPU is not requesting.
module stump_mem_arbiter
  import stump_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  stump_mem_arbiter_if.slave  bus,
  output arb_state_t          dbg_state
);

  arb_state_t        state_q, state_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic              force_gnt;
  logic              grant;
  logic              done;
  logic              stall;
  logic              ren;
  logic              wen;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

`ifdef STUMP_ARB_STARVE_GUARD_EN
  logic starve_inc;
  logic starve_clr;

  // Only a real contention loss in IDLE counts as starvation.
  assign starve_inc = (state_q == ARB_IDLE) && bus.dma_req && bus.cpu_req && !grant;
  assign starve_clr = grant || !bus.dma_req;

  stump_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .hit (force_gnt)
  );
`else
  logic unused_starve_limit;

  assign force_gnt           = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  // Port ownership, strobes and next state; reset forces every strobe low.
  always_comb begin
    state_d     = state_q;
    dma_rdata_d = dma_rdata_q;
    grant       = 1'b0;
    done        = 1'b0;
    stall       = 1'b0;
    ren         = 1'b0;
    wen         = 1'b0;
    addr        = bus.cpu_addr;
    wdata       = bus.cpu_wdata;
    case (state_q)
      ARB_IDLE: begin
        if (bus.dma_req && (!bus.cpu_req || force_gnt)) begin
          grant   = 1'b1;
          stall   = bus.cpu_req;
          ren     = !bus.dma_wen;
          wen     = bus.dma_wen;
          addr    = bus.dma_addr;
          wdata   = bus.dma_wdata;
          state_d = ARB_ACK;
          if (!bus.dma_wen) begin
            dma_rdata_d = bus.mem_rdata;
          end
        end else begin
          ren = bus.cpu_req && !bus.cpu_wen;
          wen = bus.cpu_req && bus.cpu_wen;
        end
      end
      ARB_ACK: begin
        // dma_req is ignored here: no back-to-back DMA grants.
        done    = 1'b1;
        ren     = bus.cpu_req && !bus.cpu_wen;
        wen     = bus.cpu_req && bus.cpu_wen;
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    if (rst) begin
      grant = 1'b0;
      done  = 1'b0;
      stall = 1'b0;
      ren   = 1'b0;
      wen   = 1'b0;
    end
  end

  // State and DMA read-data registers; reset abandons any pending ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign bus.cpu_stall = stall;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_gnt   = grant;
  assign bus.dma_done  = done;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.mem_ren   = ren;
  assign bus.mem_wen   = wen;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// Self-checking bench for stump_mem_arbiter: directed scenarios followed by
// randomized CPU/DMA traffic, all checked against a cycle-level model of the
// arbitration rules (CPU priority, one-cycle DMA grant, mandatory CPU cycle
// after each grant, optional starvation forcing).
module tb_stump_mem_arbiter;
  import stump_mem_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic       clk;
  logic       rst;
  arb_state_t dbg_state_unused;

  stump_mem_arbiter_if bus ();

  stump_mem_arbiter #(
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state_unused)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int bad;

  // Reference model: was the previous cycle a DMA grant, how many
  // consecutive contention cycles the DMA has lost, and captured read data.
  logic        m_prev_gnt;
  logic        m_prev_read;
  int          m_denied;
  logic [15:0] m_cap;

  // Expectations and observations of the most recent step.
  logic        e_gnt, e_done;
  logic        o_gnt, o_done, o_stall, o_ren, o_wen;
  logic [15:0] o_addr, o_wdata, o_rdata, o_cpu_rdata;

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_gnt  = 1'b0;
    m_prev_read = 1'b0;
    m_denied    = 0;
    m_cap       = 16'h0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_dma_gnt"},   bus.dma_gnt,   1'b0);
    check1({tag, "_dma_done"},  bus.dma_done,  1'b0);
    check1({tag, "_cpu_stall"}, bus.cpu_stall, 1'b0);
    check1({tag, "_mem_ren"},   bus.mem_ren,   1'b0);
    check1({tag, "_mem_wen"},   bus.mem_wen,   1'b0);
    check16({tag, "_dma_rdata"}, bus.dma_rdata, 16'h0000);
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic c_req, input logic c_wen,
                      input logic [15:0] c_addr, input logic [15:0] c_wdata,
                      input logic d_req, input logic d_wen,
                      input logic [15:0] d_addr, input logic [15:0] d_wdata,
                      input logic [15:0] m_rdata);
    logic forced;
    logic e_ren, e_wen;
    bus.cpu_req   = c_req;
    bus.cpu_wen   = c_wen;
    bus.cpu_addr  = c_addr;
    bus.cpu_wdata = c_wdata;
    bus.dma_req   = d_req;
    bus.dma_wen   = d_wen;
    bus.dma_addr  = d_addr;
    bus.dma_wdata = d_wdata;
    bus.mem_rdata = m_rdata;
`ifdef STUMP_ARB_STARVE_GUARD_EN
    forced = (m_denied >= LIMIT);
`else
    forced = 1'b0;
`endif
    e_gnt  = !m_prev_gnt && d_req && (!c_req || forced);
    e_done = m_prev_gnt;
    e_ren  = e_gnt ? !d_wen : (c_req && !c_wen);
    e_wen  = e_gnt ? d_wen : (c_req && c_wen);
    #3;
    o_gnt       = bus.dma_gnt;
    o_done      = bus.dma_done;
    o_stall     = bus.cpu_stall;
    o_ren       = bus.mem_ren;
    o_wen       = bus.mem_wen;
    o_addr      = bus.mem_addr;
    o_wdata     = bus.mem_wdata;
    o_rdata     = bus.dma_rdata;
    o_cpu_rdata = bus.cpu_rdata;
    check1("dma_gnt", o_gnt, e_gnt);
    check1("cpu_stall", o_stall, e_gnt && c_req);
    check1("dma_done", o_done, e_done);
    check1("mem_ren", o_ren, e_ren);
    check1("mem_wen", o_wen, e_wen);
    check16("cpu_rdata", o_cpu_rdata, m_rdata);
    if (e_ren || e_wen) check16("mem_addr", o_addr, e_gnt ? d_addr : c_addr);
    if (e_wen) check16("mem_wdata", o_wdata, e_gnt ? d_wdata : c_wdata);
    if (e_done && m_prev_read) check16("dma_rdata", o_rdata, m_cap);
    @(posedge clk);
    #1;
    if (e_gnt && !d_wen) m_cap = m_rdata;
    m_prev_read = e_gnt && !d_wen;
    if (e_gnt || !d_req) begin
      m_denied = 0;
    end else if (!m_prev_gnt && c_req && (m_denied < 7)) begin
      m_denied = m_denied + 1;
    end
    m_prev_gnt = e_gnt;
  endtask

  // Directed steps, then random traffic, then the summary.
  initial begin
    int          first_gnt;
    logic        stall_seen;
    logic        d_act, d_w;
    logic [15:0] d_a, d_d;

    total = 0;
    bad   = 0;
    model_reset();

    // Reset with both requesters active: everything held quiet.
    rst           = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_wen   = 1'b0;
    bus.cpu_addr  = 16'h1111;
    bus.cpu_wdata = 16'h2222;
    bus.dma_req   = 1'b1;
    bus.dma_wen   = 1'b0;
    bus.dma_addr  = 16'h3333;
    bus.dma_wdata = 16'h4444;
    bus.mem_rdata = 16'h5555;
    #3;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst1");
    rst = 1'b0;

    // CPU read, no DMA.
    step(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h5A5A);
    check1("s1_ren", o_ren, 1'b1);
    check16("s1_addr", o_addr, 16'h0010);
    check16("s1_cpu_rdata", o_cpu_rdata, 16'h5A5A);
    check1("s1_stall", o_stall, 1'b0);

    // DMA read with the CPU idle: grant now, done and data next cycle.
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'hBEEF);
    check1("s2_gnt", o_gnt, 1'b1);
    check16("s2_addr", o_addr, 16'h0200);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h1111);
    check1("s2_done", o_done, 1'b1);
    check16("s2_rdata", o_rdata, 16'hBEEF);
    check1("s2_no_regnt", o_gnt, 1'b0);

    // DMA write: exactly one write strobe.
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0300, 16'h1234, 16'h0000);
    check1("s5_wen", o_wen, 1'b1);
    check16("s5_addr", o_addr, 16'h0300);
    check16("s5_wdata", o_wdata, 16'h1234);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0300, 16'h1234, 16'h0000);
    check1("s5_wen_once", o_wen, 1'b0);
    check1("s5_done", o_done, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);

    // Continuous contention: starvation behaviour.
    first_gnt  = 0;
    stall_seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h0500, 16'h0000, 16'(i));
      if (o_stall) stall_seen = 1'b1;
      if (o_gnt && (first_gnt == 0)) first_gnt = i;
`ifdef STUMP_ARB_STARVE_GUARD_EN
      if (i == 6) begin
        check1("s4_ack_done", o_done, 1'b1);
        check1("s4_ack_cpu_ren", o_ren, 1'b1);
        check1("s4_ack_stall", o_stall, 1'b0);
      end
`endif
    end
`ifdef STUMP_ARB_STARVE_GUARD_EN
    check16("s4_first_gnt", 16'(first_gnt), 16'd5);
    check1("s4_stall_seen", stall_seen, 1'b1);
`else
    check16("s3_first_gnt", 16'(first_gnt), 16'd0);
    check1("s3_stall_seen", stall_seen, 1'b0);
`endif
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);

    // Reset during ACK: transfer abandoned, no done pulse.
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'hCAFE);
    check1("s6_gnt", o_gnt, 1'b1);
    bus.cpu_req = 1'b1;
    rst         = 1'b1;
    #2;
    check_reset_outputs("s6_rst_a");
    @(posedge clk);
    #1;
    check_reset_outputs("s6_rst_b");
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'hD00D);
    check1("s6_no_done", o_done, 1'b0);
    check1("s6_regnt", o_gnt, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000);
    check16("s6_rdata", o_rdata, 16'hD00D);

    // Random traffic from a protocol-respecting DMA and a busy CPU.
    d_act = 1'b0;
    d_w   = 1'b0;
    d_a   = 16'h0000;
    d_d   = 16'h0000;
    for (int i = 0; i < 3000; i++) begin
      if (!d_act && ($urandom_range(0, 2) == 0)) begin
        d_act = 1'b1;
        d_w   = 1'($urandom_range(0, 1));
        d_a   = 16'($urandom);
        d_d   = 16'($urandom);
      end
      step(($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
           d_act, d_w, d_a, d_d, 16'($urandom));
      if (e_done) d_act = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stump_mem_arbiter.md
STUMP_MEM_ARBITER -- requirements
Module: stump_mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive denied DMA cycles before a forced DMA grant (legal 1..7).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_req  input  1  Stump needs the memory port this cycle (fetch or memory-state access).
REQ-005 cpu_wen  input  1  1 = CPU write, 0 = CPU read.
REQ-006 cpu_addr, cpu_wdata  input  16 each  CPU address and write data.
REQ-007 cpu_stall  output  1  CPU shall hold its state and retry; the access was not performed.
REQ-008 cpu_rdata  output  16  mem_rdata passed through combinationally.
REQ-009 dma_req  input  1  DMA request; held high until dma_done.
REQ-010 dma_wen  input  1  DMA write or read.
REQ-011 dma_addr, dma_wdata  input  16 each  DMA address and write data.
REQ-012 dma_gnt  output  1  DMA access performed this cycle.
REQ-013 dma_done  output  1  one-cycle completion pulse, the cycle after dma_gnt.
REQ-014 dma_rdata  output  16  registered read data, valid while dma_done=1.
REQ-015 mem_ren, mem_wen  output  1 each  memory read and write strobes.
REQ-016 mem_addr, mem_wdata  output  16 each  muxed address and write data.
REQ-017 mem_rdata  input  16  combinational read data, same cycle as mem_ren.

Function
REQ-018 FSM states: IDLE and ACK; the port is owned per cycle and never by both requesters.
REQ-019 IDLE with dma_req=1 and (cpu_req=0 or forced grant): DMA drives mem_*; mem_ren=!dma_wen; mem_wen=dma_wen; dma_gnt=1; cpu_stall=cpu_req; mem_rdata captured into dma_rdata; next state ACK.
REQ-020 IDLE otherwise: the CPU drives mem_* when cpu_req=1 (mem_ren=!cpu_wen, mem_wen=cpu_wen); cpu_stall=0; both strobes 0 when cpu_req=0; stay in IDLE.
REQ-021 ACK: dma_done=1 for exactly one cycle; the CPU owns the port unconditionally; dma_req is ignored; next state IDLE.
REQ-022 A new DMA grant is never issued in ACK, so the CPU gets at least every second cycle.
REQ-023 DMA latency: grant at the earliest in the cycle dma_req rises; dma_done exactly 1 cycle after the grant.
REQ-024 mem_addr and mem_wdata are don't-care when both strobes are 0; mem_ren and mem_wen are never both 1.
REQ-025 Simultaneous cpu_req and dma_req with no forced grant: the CPU wins; the DMA waits with no side effects.

Reset
REQ-026 While rst=1: state=IDLE; starvation count=0; dma_rdata=0; dma_gnt, dma_done, cpu_stall, mem_ren and mem_wen all 0.
REQ-027 Reset asserted in ACK abandons the transfer: no dma_done pulse follows; the DMA shall re-request.
REQ-028 First edge after rst falls: normal IDLE arbitration.

Configuration
REQ-029 Macro STUMP_ARB_STARVE_GUARD_EN defined: a 3-bit counter increments on each IDLE cycle with dma_req=1 and cpu_req=1 that is not granted; count reaching STARVE_LIMIT forces a DMA grant next IDLE cycle.
REQ-030 The counter clears on any dma_gnt and whenever dma_req=0; it saturates and never wraps.
REQ-031 Macro undefined: strict CPU priority; the DMA is granted only when cpu_req=0; no counter is synthesised.

Structure
REQ-032 Shared Stump definitions file holds the ARB_IDLE/ARB_ACK state encodings and the STARVE_LIMIT default.
REQ-033 One sub-module, stump_starve_counter (count, clear, saturate, limit-hit flag), instantiated only under STUMP_ARB_STARVE_GUARD_EN.

Verification
REQ-034 Scenario 1: cpu_req=1 and cpu_wen=0 with addr 0x0010, no DMA -> mem_ren=1 and mem_addr=0x0010; cpu_rdata=mem_rdata; cpu_stall=0.
REQ-035 Scenario 2: cpu_req=0 with a DMA read of 0x0200 and mem_rdata=0xBEEF -> dma_gnt in cycle N; dma_done=1 and dma_rdata=0xBEEF in N+1.
REQ-036 Scenario 3: cpu_req held 1 and dma_req 1, guard off -> DMA never granted and cpu_stall never 1.
REQ-037 Scenario 4: same stimulus, guard on, STARVE_LIMIT=4 -> the 5th DMA-pending cycle has dma_gnt=1 and cpu_stall=1; the next cycle is ACK with the CPU served.
REQ-038 Scenario 5: DMA write 0x1234 to 0x0300 -> mem_wen=1, mem_addr=0x0300, mem_wdata=0x1234 for exactly one cycle.
REQ-039 Scenario 6: rst pulsed during ACK -> dma_done stays 0; all outputs are at reset values during rst.
